// File: rtl/prince_mprime_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prince_mprime_pipe
// Brief    : Registered multi-share PRINCE M' layer with a 1-entry skid buffer.
// Revision : 1.0
// ============================================================================
module prince_mprime_pipe #(
    parameter int NSHARES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [64*NSHARES-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [64*NSHARES-1:0]  out_data
);

    localparam int W = 64 * NSHARES;

    // Nibble-matrix form: input nibble k contributes to output nibble r through
    // an identity with one bit removed, the removed bit rotating with (r+k+off).
    function automatic logic [15:0] mhat(input logic [15:0] c, input logic [1:0] off);
        logic [15:0] y;
        logic [3:0]  acc;
        logic [1:0]  idx;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                idx = 2'(r + k) + off;
                acc = acc ^ (c[15-4*k -: 4] & ~(4'b1000 >> idx));
            end
            y[15-4*r -: 4] = acc;
        end
        return y;
    endfunction

    function automatic logic [63:0] mprime(input logic [63:0] x);
        return {mhat(x[63:48], 2'd0), mhat(x[47:32], 2'd1),
                mhat(x[31:16], 2'd1), mhat(x[15:0],  2'd0)};
    endfunction

    logic [W-1:0] mp_in;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_full_q, skid_full_d;
    logic         in_acc, out_acc;

    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        assign mp_in[64*s +: 64] = mprime(in_data[64*s +: 64]);
    end

    assign in_ready  = ~skid_full_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign in_acc    = in_valid & ~skid_full_q;
    assign out_acc   = main_valid_q & out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_full_d  = skid_full_q;
        if (flush_i) begin
            main_data_d  = '0;
            main_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_full_d  = 1'b0;
        end else if (out_acc && skid_full_q) begin
            main_data_d = skid_data_q;
            skid_full_d = 1'b0;
        end else if (out_acc) begin
            if (in_acc) begin
                main_data_d  = mp_in;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid_q) begin
            if (in_acc) begin
                main_data_d  = mp_in;
                main_valid_d = 1'b1;
            end
        end else if (in_acc) begin
            // Main is stalled: park the new block in the skid register.
            skid_data_d = mp_in;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_full_q  <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_full_q  <= skid_full_d;
        end
    end

endmodule
`default_nettype wire
